// File: rtl/add_rca_seq.sv
// Multi-cycle ripple-carry adder/subtractor: one CHUNK-bit slice per clock, LSB slice first.
// Operands are shifted down as slices are consumed; results appear only at completion.
module add_rca_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_last;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_work;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [CHUNK:0]   w_chunk;
    logic             w_c_msb;
    logic [WIDTH-1:0] w_work_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_idx == IDXW'(NCHUNK - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Current slice always sits in the low bits of r_a/r_b; the finished slice
    // enters r_work from the top, so after NCHUNK steps it holds the full result.
    always_comb begin
        w_chunk    = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};
        w_c_msb    = w_chunk[CHUNK-1] ^ r_a[CHUNK-1] ^ r_b[CHUNK-1];
        w_work_nxt = (r_work >> CHUNK) | (WIDTH'(w_chunk[CHUNK-1:0]) << (WIDTH - CHUNK));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_work  <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_a     <= a;
                r_b     <= sub ? ~b : b;
                r_carry <= sub ? 1'b1 : c_in;
                r_idx   <= '0;
            end else if (r_state == RUN) begin
                r_a     <= r_a >> CHUNK;
                r_b     <= r_b >> CHUNK;
                r_carry <= w_chunk[CHUNK];
                r_work  <= w_work_nxt;
                r_idx   <= r_idx + 1'b1;
            end
            // On the last slice w_c_msb is the carry into bit WIDTH-1.
            if (w_last) begin
                r_sum  <= w_work_nxt;
                r_cout <= w_chunk[CHUNK];
                r_ovf  <= w_c_msb ^ w_chunk[CHUNK];
            end
        end
    end

    assign busy  = (r_state == RUN);
    assign done  = r_done;
    assign sum   = r_sum;
    assign c_out = r_cout;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_add_rca_seq.sv
// Bench for add_rca_seq: directed cases on the 16/4 build, then random ops on four builds
// (16/4, 16/1, 16/16, 32/8) against an integer-arithmetic reference.
module tb_add_rca_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, sub, c_in;
    logic [31:0] a, b;

    logic        busy0, done0, co0, ov0;
    logic [15:0] s0;
    logic        busy1, done1, co1, ov1;
    logic [15:0] s1;
    logic        busy2, done2, co2, ov2;
    logic [15:0] s2;
    logic        busy3, done3, co3, ov3;
    logic [31:0] s3;

    add_rca_seq #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a[15:0]), .b(b[15:0]), .c_in(c_in),
        .busy(busy0), .done(done0), .sum(s0), .c_out(co0), .ovf(ov0));
    add_rca_seq #(.WIDTH(16), .CHUNK(1)) u_dut_c1 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a[15:0]), .b(b[15:0]), .c_in(c_in),
        .busy(busy1), .done(done1), .sum(s1), .c_out(co1), .ovf(ov1));
    add_rca_seq #(.WIDTH(16), .CHUNK(16)) u_dut_c16 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a[15:0]), .b(b[15:0]), .c_in(c_in),
        .busy(busy2), .done(done2), .sum(s2), .c_out(co2), .ovf(ov2));
    add_rca_seq #(.WIDTH(32), .CHUNK(8)) u_dut_w32 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .c_in(c_in),
        .busy(busy3), .done(done3), .sum(s3), .c_out(co3), .ovf(ov3));

    logic        od[4];
    logic        oc[4];
    logic        oo[4];
    logic [31:0] os[4];
    always_comb begin
        od[0] = done0; oc[0] = co0; oo[0] = ov0; os[0] = {16'h0, s0};
        od[1] = done1; oc[1] = co1; oo[1] = ov1; os[1] = {16'h0, s1};
        od[2] = done2; oc[2] = co2; oo[2] = ov2; os[2] = {16'h0, s2};
        od[3] = done3; oc[3] = co3; oo[3] = ov3; os[3] = s3;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // True integer result of a+b+c_in or a-b at width w.
    function automatic void model(input int w, input logic s, input logic [31:0] x,
                                  input logic [31:0] y, input logic ci,
                                  output logic [31:0] rs, output logic rc, output logic ro);
        longint m, ux, uy, t, sx, sy, r;
        m  = longint'(1) << w;
        ux = longint'(x) & (m - 1);
        uy = longint'(y) & (m - 1);
        if (s) t = ux - uy + m;
        else   t = ux + uy + longint'(ci);
        rs = 32'(t & (m - 1));
        rc = s ? (ux >= uy) : (((t >> w) & 1) != 0);
        sx = (ux >= m / 2) ? ux - m : ux;
        sy = (uy >= m / 2) ? uy - m : uy;
        r  = s ? sx - sy : sx + sy + longint'(ci);
        ro = (r < -(m / 2)) || (r >= m / 2);
    endfunction

    // One op on the 16/4 build; inject >= 0 pulses start with junk operands at that
    // cycle of the run. Returns at the cycle where done is seen.
    task automatic do_op(input string tag, input logic s, input logic [31:0] x,
                         input logic [31:0] y, input logic ci, input int inject);
        logic [15:0] prev_s;
        logic        prev_c, prev_o, ec, eo;
        logic [31:0] es;
        int          lat, nbusy;
        prev_s = s0; prev_c = co0; prev_o = ov0;
        model(16, s, x, y, ci, es, ec, eo);
        sub = s; a = x; b = y; c_in = ci; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; nbusy = 0;
        while (!done0 && lat < 40) begin
            if (busy0) nbusy++;
            chk({tag, ".hold"}, {s0, co0, ov0}, {prev_s, prev_c, prev_o});
            a = $urandom; b = $urandom; sub = 1'($urandom); c_in = 1'($urandom);
            start = (lat == inject) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        chk({tag, ".lat"}, lat, 4);
        chk({tag, ".busycyc"}, nbusy, 4);
        chk({tag, ".busy_at_done"}, busy0, 0);
        chk({tag, ".sum"}, s0, es[15:0]);
        chk({tag, ".cout"}, co0, ec);
        chk({tag, ".ovf"}, ov0, eo);
    endtask

    task automatic rnd_op(input int n);
        logic        s, ci;
        logic [31:0] x, y, es;
        logic        ec, eo;
        int          lat[4];
        logic [31:0] cs[4];
        logic        cc[4], co[4];
        int          cyc, w;
        s = 1'($urandom); ci = 1'($urandom); x = $urandom; y = $urandom;
        if (n % 8 == 0) y = x;
        if (n % 8 == 1) x = 32'hFFFF_FFFF;
        sub = s; a = x; b = y; c_in = ci; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin lat[i] = -1; cs[i] = '0; cc[i] = 1'b0; co[i] = 1'b0; end
        cyc = 0;
        while ((lat[0] < 0 || lat[1] < 0 || lat[2] < 0 || lat[3] < 0) && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            a = $urandom; b = $urandom;
            for (int i = 0; i < 4; i++) begin
                if (od[i] && lat[i] < 0) begin
                    lat[i] = cyc; cs[i] = os[i]; cc[i] = oc[i]; co[i] = oo[i];
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            w = (i == 3) ? 32 : 16;
            model(w, s, x, y, ci, es, ec, eo);
            chk($sformatf("rnd%0d.i%0d.lat", n, i), lat[i],
                (i == 0) ? 4 : (i == 1) ? 16 : (i == 2) ? 1 : 4);
            chk($sformatf("rnd%0d.i%0d.sum", n, i), cs[i], es);
            chk($sformatf("rnd%0d.i%0d.cout", n, i), cc[i], ec);
            chk($sformatf("rnd%0d.i%0d.ovf", n, i), co[i], eo);
        end
    endtask

    initial begin
        logic seen;
        rst = 1'b1; start = 1'b0; sub = 1'b0; c_in = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", {busy0, done0, s0, co0, ov0}, '0);
        rst = 1'b0;

        do_op("add_5555", 0, 32'h1234, 32'h4321, 0, -1);
        do_op("add_ffff_1", 0, 32'hFFFF, 32'h0001, 0, -1);
        do_op("add_ffff_cin", 0, 32'hFFFF, 32'h0000, 1, -1);
        do_op("add_ovf", 0, 32'h7FFF, 32'h0001, 0, -1);
        do_op("sub_5_7", 1, 32'h0005, 32'h0007, 0, -1);
        do_op("sub_8000_1", 1, 32'h8000, 32'h0001, 0, -1);
        do_op("sub_8000_1_cin", 1, 32'h8000, 32'h0001, 1, -1);

        // start pulsed mid-run must be ignored; then check done is a single pulse
        do_op("ign_start", 0, 32'h1111, 32'h2222, 0, 1);
        @(posedge clk); #1;
        chk("pulse.done", done0, 0);
        chk("pulse.busy", busy0, 0);

        // back-to-back: second start lands in the done cycle
        do_op("b2b_1", 0, 32'h0F0F, 32'h0101, 0, -1);
        do_op("b2b_2", 1, 32'h0003, 32'h0009, 0, -1);

        // reset two edges into an op
        sub = 1'b0; a = 32'hABCD; b = 32'h1111; c_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid.state", {busy0, done0, s0, co0, ov0}, '0);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            seen = seen | done0;
        end
        chk("rst_mid.no_done", seen, 0);
        do_op("after_rst", 0, 32'h8000, 32'h8000, 1, -1);

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int n = 0; n < 1000; n++) rnd_op(n);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
